// File: rtl/riscv_pc_pkg.sv
// Shared PC-select encodings and defaults for the single-cycle RISC-V fetch path.
package riscv_pc_pkg;

  typedef logic [1:0] pc_src_t;

  localparam pc_src_t PC_SRC_SEQ    = 2'b00;
  localparam pc_src_t PC_SRC_BRANCH = 2'b01;
  localparam pc_src_t PC_SRC_JALR   = 2'b10;
  localparam pc_src_t PC_SRC_RSVD   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control/datapath-facing signals of the PC unit, grouped as one bundle.
interface pc_unit_ras_if
  import riscv_pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic            stall;
  pc_src_t         pc_src;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] jalr_target;
  logic            trap_req;
  logic [XLEN-1:0] mtvec;
  logic            mret;
  logic            ras_push;
  logic            ras_pop;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] mepc;
  logic            misaligned;
  logic            trap_taken;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;

  modport master (
    output stall, pc_src, imm_ext, jalr_target, trap_req, mtvec, mret, ras_push, ras_pop,
    input  pc, pc_plus4, pc_target, mepc, misaligned, trap_taken, ras_top, ras_empty
  );

  modport slave (
    input  stall, pc_src, imm_ext, jalr_target, trap_req, mtvec, mret, ras_push, ras_pop,
    output pc, pc_plus4, pc_target, mepc, misaligned, trap_taken, ras_top, ras_empty
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; when full, a push silently overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [PtrW-1:0] ptr_q, ptr_d, wr_idx;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_en;
  logic [XLEN-1:0] mem_q [RAS_DEPTH];

  assign empty = (cnt_q == '0);
  assign top   = empty ? '0 : mem_q[ptr_q];

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (en) begin
      // Push+pop on an empty stack degenerates to a plain push.
      if (push && (!pop || empty)) begin
        wr_idx = ptr_q + PtrW'(1);
        ptr_d  = wr_idx;
        wr_en  = 1'b1;
        if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + CntW'(1);
      end else if (push) begin
        wr_en = 1'b1;
      end else if (pop && !empty) begin
        ptr_d = ptr_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Program counter with stall, trap/mret redirect, misalignment trapping and a return-address stack.
module pc_unit_ras
  import riscv_pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     IALIGN    = 4
) (
  input logic          clk,
  input logic          reset,
  pc_unit_ras_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d, mepc_q, mepc_d;
  logic            trap_taken_q, trap_taken_d;
  logic [XLEN-1:0] pc_plus4, pc_target, sel_target, trap_vec;
  logic            misaligned, ras_en;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign pc_target = pc_q + bus.imm_ext;
  assign trap_vec  = bus.mtvec & ~XLEN'(3);

  always_comb begin
    case (bus.pc_src)
      PC_SRC_BRANCH: sel_target = pc_target;
      PC_SRC_JALR:   sel_target = bus.jalr_target & ~XLEN'(1);
      default:       sel_target = pc_plus4;
    endcase
  end

  assign misaligned = (bus.pc_src != PC_SRC_SEQ) &&
                      ((IALIGN == 4) ? (sel_target[1:0] != 2'b00) : sel_target[0]);

  // Trap beats stall; a misaligned target only traps when the pipeline is moving.
  always_comb begin
    pc_d         = pc_q;
    mepc_d       = mepc_q;
    trap_taken_d = 1'b0;
    ras_en       = 1'b0;
    if (bus.trap_req) begin
      pc_d         = trap_vec;
      mepc_d       = pc_q;
      trap_taken_d = 1'b1;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (misaligned) begin
      pc_d         = trap_vec;
      mepc_d       = pc_q;
      trap_taken_d = 1'b1;
    end else if (bus.mret) begin
      pc_d = mepc_q;
    end else begin
      pc_d   = sel_target;
      ras_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VEC;
      mepc_q       <= '0;
      trap_taken_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      mepc_q       <= mepc_d;
      trap_taken_q <= trap_taken_d;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .en    (ras_en),
    .push  (bus.ras_push),
    .pop   (bus.ras_pop),
    .din   (pc_plus4),
    .top   (bus.ras_top),
    .empty (bus.ras_empty)
  );

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.pc_target  = pc_target;
  assign bus.mepc       = mepc_q;
  assign bus.misaligned = misaligned;
  assign bus.trap_taken = trap_taken_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed scenarios plus randomized traffic vs. a queue model.
module tb_pc_unit_ras;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pc_unit_ras_if #(.XLEN(32)) bus ();

  pc_unit_ras #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0100),
    .RAS_DEPTH (4),
    .IALIGN    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural PC/MEPC plus the RAS as a bounded queue (back = top).
  logic [31:0] m_pc, m_mepc;
  logic        m_tt;
  logic [31:0] m_ras[$];

  function automatic logic [31:0] exp_sel();
    case (bus.pc_src)
      2'b01:   return m_pc + bus.imm_ext;
      2'b10:   return {bus.jalr_target[31:1], 1'b0};
      default: return m_pc + 32'd4;
    endcase
  endfunction

  function automatic logic exp_mis();
    logic [31:0] s;
    s = exp_sel();
    return (bus.pc_src != 2'b00) && ((s % 32'd4) != 32'd0);
  endfunction

  function automatic logic [31:0] exp_top();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
  endfunction

  task automatic model_reset();
    m_pc   = 32'h100;
    m_mepc = 32'h0;
    m_tt   = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [31:0] sel, lnk;
    sel = exp_sel();
    lnk = m_pc + 32'd4;
    if (bus.trap_req || (!bus.stall && exp_mis())) begin
      m_mepc = m_pc;
      m_pc   = bus.mtvec & ~32'h3;
      m_tt   = 1'b1;
    end else if (bus.stall) begin
      m_tt = 1'b0;
    end else if (bus.mret) begin
      m_pc = m_mepc;
      m_tt = 1'b0;
    end else begin
      if (bus.ras_push && bus.ras_pop && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = lnk;
      end else if (bus.ras_push) begin
        m_ras.push_back(lnk);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (bus.ras_pop && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
      m_pc = sel;
      m_tt = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall       = 1'b0;
    bus.pc_src      = 2'b00;
    bus.imm_ext     = 32'h0;
    bus.jalr_target = 32'h0;
    bus.trap_req    = 1'b0;
    bus.mtvec       = 32'h800;
    bus.mret        = 1'b0;
    bus.ras_push    = 1'b0;
    bus.ras_pop     = 1'b0;
  endtask

  // Branch to an aligned absolute address without touching the RAS.
  task automatic goto(input logic [31:0] addr);
    idle();
    bus.pc_src  = 2'b01;
    bus.imm_ext = addr - m_pc;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++; if (bus.pc !== 32'h100) begin n_errors++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h100); end
    n_checks++; if (bus.mepc !== 32'h0) begin n_errors++; $display("FAIL reset_mepc got=%h exp=0", bus.mepc); end
    n_checks++; if (bus.trap_taken !== 1'b0) begin n_errors++; $display("FAIL reset_tt got=%b exp=0", bus.trap_taken); end
    n_checks++; if (bus.ras_empty !== 1'b1 || bus.ras_top !== 32'h0) begin
      n_errors++; $display("FAIL reset_ras empty=%b top=%h exp empty=1 top=0", bus.ras_empty, bus.ras_top);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h104, 32'h108, 32'h10C};
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.pc !== exp_pc[i]) begin n_errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.pc, exp_pc[i]); end
    end
    n_checks++; if (bus.ras_empty !== 1'b1) begin n_errors++; $display("FAIL seq_empty got=%b exp=1", bus.ras_empty); end
  endtask

  task automatic test_branch_jalr();
    goto(32'h200);
    bus.pc_src  = 2'b01;
    bus.imm_ext = 32'hFFFF_FFF0;
    #1;
    n_checks++; if (bus.pc_target !== 32'h1F0) begin n_errors++; $display("FAIL br_target got=%h exp=1f0", bus.pc_target); end
    tick();
    n_checks++; if (bus.pc !== 32'h1F0) begin n_errors++; $display("FAIL br_pc got=%h exp=1f0", bus.pc); end
    bus.pc_src      = 2'b10;
    bus.jalr_target = 32'h301;
    #1;
    n_checks++; if (bus.misaligned !== 1'b0) begin n_errors++; $display("FAIL jalr_mis got=%b exp=0", bus.misaligned); end
    tick();
    n_checks++; if (bus.pc !== 32'h300) begin n_errors++; $display("FAIL jalr_pc got=%h exp=300", bus.pc); end
    idle();
  endtask

  task automatic test_misaligned_trap();
    goto(32'h40);
    bus.pc_src  = 2'b01;
    bus.imm_ext = 32'h6;
    #1;
    n_checks++; if (bus.misaligned !== 1'b1) begin n_errors++; $display("FAIL mis_flag got=%b exp=1", bus.misaligned); end
    tick();
    n_checks++; if (bus.pc !== 32'h800 || bus.mepc !== 32'h40 || bus.trap_taken !== 1'b1) begin
      n_errors++; $display("FAIL mis_trap pc=%h mepc=%h tt=%b exp 800/40/1", bus.pc, bus.mepc, bus.trap_taken);
    end
    idle();
    bus.mret = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 32'h40 || bus.trap_taken !== 1'b0) begin
      n_errors++; $display("FAIL mret_pc pc=%h tt=%b exp 40/0", bus.pc, bus.trap_taken);
    end
    idle();
  endtask

  task automatic test_trap_stall();
    goto(32'h50);
    bus.trap_req = 1'b1;
    bus.stall    = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 32'h800 || bus.mepc !== 32'h50) begin
      n_errors++; $display("FAIL trap_over_stall pc=%h mepc=%h exp 800/50", bus.pc, bus.mepc);
    end
    goto(32'h60);
    bus.stall    = 1'b1;
    bus.ras_push = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.pc !== 32'h60 || bus.trap_taken !== 1'b0) begin
        n_errors++; $display("FAIL stall_hold%0d pc=%h tt=%b exp 60/0", i, bus.pc, bus.trap_taken);
      end
    end
    n_checks++; if (bus.ras_empty !== 1'b1 || bus.ras_top !== 32'h0) begin
      n_errors++; $display("FAIL stall_ras empty=%b top=%h exp 1/0", bus.ras_empty, bus.ras_top);
    end
    idle();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_tops [3] = '{32'h44, 32'h34, 32'h24};
    for (int i = 1; i <= 5; i++) begin
      goto(32'(i * 16));
      bus.ras_push = 1'b1;
      tick();
    end
    idle();
    n_checks++; if (bus.ras_top !== 32'h54) begin n_errors++; $display("FAIL ovf_top got=%h exp=54", bus.ras_top); end
    bus.ras_pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.ras_top !== exp_tops[i] || bus.ras_empty !== 1'b0) begin
        n_errors++; $display("FAIL pop_top%0d got=%h empty=%b exp=%h", i, bus.ras_top, bus.ras_empty, exp_tops[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.ras_empty !== 1'b1 || bus.ras_top !== 32'h0) begin
        n_errors++; $display("FAIL pop_empty%0d empty=%b top=%h exp 1/0", i, bus.ras_empty, bus.ras_top);
      end
    end
    idle();
  endtask

  task automatic test_coroutine();
    goto(32'h10); bus.ras_push = 1'b1; tick();
    goto(32'h20); bus.ras_push = 1'b1; tick();
    goto(32'h90);
    bus.ras_push = 1'b1;
    bus.ras_pop  = 1'b1;
    tick();
    n_checks++; if (bus.ras_top !== 32'h94) begin n_errors++; $display("FAIL corout_top got=%h exp=94", bus.ras_top); end
    idle();
    bus.ras_pop = 1'b1;
    tick();
    n_checks++; if (bus.ras_top !== 32'h14 || bus.ras_empty !== 1'b0) begin
      n_errors++; $display("FAIL corout_count top=%h empty=%b exp 14/0", bus.ras_top, bus.ras_empty);
    end
    idle();
  endtask

  task automatic test_async_reset();
    goto(32'h300);
    bus.ras_push = 1'b1;
    tick();
    idle();
    reset = 1'b1;
    #2;
    n_checks++; if (bus.pc !== 32'h100 || bus.ras_empty !== 1'b1 || bus.mepc !== 32'h0) begin
      n_errors++; $display("FAIL async_reset pc=%h empty=%b mepc=%h exp 100/1/0", bus.pc, bus.ras_empty, bus.mepc);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      bus.stall       = ($urandom_range(0, 7) == 0);
      bus.trap_req    = ($urandom_range(0, 15) == 0);
      bus.mret        = ($urandom_range(0, 15) == 0);
      bus.pc_src      = 2'($urandom_range(0, 3));
      bus.imm_ext     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : -32'($urandom_range(0, 63));
      bus.jalr_target = $urandom;
      bus.mtvec       = $urandom;
      bus.ras_push    = $urandom_range(0, 1) == 1;
      bus.ras_pop     = $urandom_range(0, 1) == 1;
      #1;
      n_checks++; if (bus.misaligned !== exp_mis()) begin
        n_errors++; $display("FAIL rnd_mis it=%0d got=%b exp=%b", it, bus.misaligned, exp_mis());
      end
      n_checks++; if (bus.pc_plus4 !== m_pc + 32'd4 || bus.pc_target !== m_pc + bus.imm_ext) begin
        n_errors++; $display("FAIL rnd_adders it=%0d p4=%h tgt=%h exp %h/%h", it, bus.pc_plus4, bus.pc_target,
                             m_pc + 32'd4, m_pc + bus.imm_ext);
      end
      tick();
      n_checks++; if (bus.pc !== m_pc || bus.mepc !== m_mepc || bus.trap_taken !== m_tt) begin
        n_errors++; $display("FAIL rnd_state it=%0d pc=%h mepc=%h tt=%b exp %h/%h/%b", it, bus.pc, bus.mepc,
                             bus.trap_taken, m_pc, m_mepc, m_tt);
      end
      n_checks++; if (bus.ras_top !== exp_top() || bus.ras_empty !== (m_ras.size() == 0)) begin
        n_errors++; $display("FAIL rnd_ras it=%0d top=%h empty=%b exp %h/%b", it, bus.ras_top, bus.ras_empty,
                             exp_top(), m_ras.size() == 0);
      end
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    test_reset();
    test_sequential();
    test_branch_jalr();
    test_misaligned_trap();
    test_trap_stall();
    test_ras_overflow();
    test_coroutine();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
